share_encoder: RTL and testbench
================================

SHARE_ENCODER -- requirements
Module: share_encoder

Interface
REQ-001 Parameter LFSR_W, default 16, width of the internal mask-generator state; only 16 is supported.
REQ-002 Parameter SEED_DEFAULT, default 16'hACE1, seed substituted when an all-zero seed is loaded.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_seed_load  input  1  load i_seed into the mask generator this cycle.
REQ-006 i_seed  input  LFSR_W  seed value.
REQ-007 i_valid  input  1  plaintext pair i_A/i_B is presented.
REQ-008 o_ready  output  1  encoder accepts a plaintext pair this cycle.
REQ-009 i_A, i_B  input  1 each  unmasked plaintext bits.
REQ-010 o_valid  output  1  output share register holds an unconsumed encoding.
REQ-011 i_ready  input  1  downstream masked gadget consumes the encoding.
REQ-012 o_A0, o_A1, o_B0, o_B1  output  1 each  two-share encodings of A and B.
REQ-013 o_rN  output  1  fresh refresh bit for the downstream gadget.
REQ-014 o_count  output  16  number of accepted encodings, saturating.

Function
REQ-015 FSM states: UNSEEDED (after reset) and RUN; UNSEEDED->RUN on i_seed_load; RUN->RUN on i_seed_load (reseed); no other transitions.
REQ-016 o_ready = (state==RUN) && !i_seed_load && (!o_valid || i_ready).
REQ-017 Accept = i_valid && o_ready; accepted pair appears on outputs with o_valid=1 exactly one cycle later (latency 1).
REQ-018 LFSR single step: new = s[0]^s[2]^s[3]^s[5]; s <= {new, s[15:1]}.
REQ-019 On accept: mA=s[0], mB=s[1], r=s[2]; registered o_A0=i_A^mA, o_A1=mA, o_B0=i_B^mB, o_B1=mB, o_rN=r.
REQ-020 On accept the LFSR advances exactly three single steps in that cycle; it holds otherwise.
REQ-021 Mask bits are never reused: no two accepted pairs use the same LFSR state.
REQ-022 i_seed_load loads i_seed (or SEED_DEFAULT if i_seed==0); LFSR state is never zero.
REQ-023 Seed load with simultaneous i_valid: seed wins, pair not accepted (o_ready=0), upstream must hold.
REQ-024 Seed load while o_valid=1: the output register and o_valid are unaffected; i_ready may still consume it.
REQ-025 o_valid=1 && i_ready=0: all o_* share outputs hold stable; no new accept.
REQ-026 o_valid=1 && i_ready=1 && accept: back-to-back, o_valid stays 1 with the new encoding.
REQ-027 o_valid=1 && i_ready=1 && no accept: o_valid falls to 0 next cycle.
REQ-028 o_count increments by 1 on each accept, saturates at 16'hFFFF, and is not cleared by reseed.

Reset
REQ-029 rst_n low asynchronously forces state=UNSEEDED, LFSR=SEED_DEFAULT, o_valid=0, o_A0/o_A1/o_B0/o_B1/o_rN=0, and o_count=0.
REQ-030 Reset mid-transaction discards any pending encoding, and a seed load is required before the next accept.

Structure
REQ-031 The shared masking package holds the FSM state enum, LFSR_W, SEED_DEFAULT and the tap list.
REQ-032 The LFSR is one sub-module, mask_lfsr, providing a three-step advance, load and state output.
REQ-033 The output share register is the module's only pipeline stage; no combinational path runs from i_A/i_B to outputs.

Verification
REQ-034 Reset, then i_valid=1 with no seed load -> o_ready=0 indefinitely and o_valid=0.
REQ-035 Seed 16'hACE1, then accept A=1,B=1 -> next cycle o_A0=0,o_A1=1,o_B0=1,o_B1=0,o_rN=0, and LFSR=16'h559C.
REQ-036 Second accept A=0,B=1 -> o_A0=0,o_A1=0,o_B0=1,o_B1=0,o_rN=1; for every accept, A0^A1==A and B0^B1==B.
REQ-037 Seed 0 -> LFSR=16'hACE1; i_ready=0 for 5 cycles with o_valid=1 -> outputs stable, o_ready=0, and LFSR unchanged.
REQ-038 Seed load coincident with i_valid and pending o_valid -> pair not accepted, pending output retained, and new seed in effect.
REQ-039 Continuous accepts with i_ready=1 -> one encoding per cycle, and o_count reaches 16'hFFFF and holds.

Source files
------------

// File: rtl/share_encoder_pkg.sv
// Shared definitions for the two-share Boolean masking encoder:
// encoder FSM states, mask generator width, default seed and LFSR taps.
package share_encoder_pkg;

   localparam int LFSR_W = 16;

   // Seed used out of reset and whenever an all-zero seed is loaded.
   // An all-zero LFSR would lock up and emit constant masks.
   localparam logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1;

   // Feedback taps: bits 0, 2, 3 and 5.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

   typedef enum logic {
      UNSEEDED = 1'b0,
      RUN      = 1'b1
   } enc_state_t;

   // One Fibonacci step: the feedback bit enters at the top and the state
   // shifts towards bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/share_encoder_mask_lfsr.sv
// Mask generator for the share encoder. Each consumed encoding uses three
// state bits (two masks and one refresh bit), so the register moves three
// single steps at once. This way no two encodings ever see the same state.
module mask_lfsr
   import share_encoder_pkg::*;
#(
   parameter logic [LFSR_W-1:0] RESET_SEED = SEED_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              advance,
   output logic [LFSR_W-1:0] state
);

   logic [LFSR_W-1:0] state_q;
   logic [LFSR_W-1:0] state_d;

   // Next state: a load replaces the state (never with zero); an advance
   // moves three steps; otherwise hold.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = (seed == '0) ? RESET_SEED : seed;
      end else if (advance) begin
         state_d = lfsr_step(lfsr_step(lfsr_step(state_q)));
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RESET_SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/share_encoder.sv
// Two-share Boolean masking encoder. It accepts a plaintext pair (A, B)
// over a valid/ready handshake and emits the registered shares
// A0 = A ^ mA, A1 = mA, B0 = B ^ mB, B1 = mB together with a fresh refresh
// bit rN. The masks come from an LFSR that must be seeded after reset.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Upstream (i_valid/o_ready) must hold its pair until accepted.
// Downstream (o_valid/i_ready) sees stable outputs while o_valid is high
// and i_ready is low.
module share_encoder #(
   parameter int                LFSR_W       = share_encoder_pkg::LFSR_W,
   parameter logic [LFSR_W-1:0] SEED_DEFAULT = share_encoder_pkg::SEED_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_seed_load,
   input  logic [LFSR_W-1:0] i_seed,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_A,
   input  logic              i_B,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_A0,
   output logic              o_A1,
   output logic              o_B0,
   output logic              o_B1,
   output logic              o_rN,
   output logic [15:0]       o_count
);

   import share_encoder_pkg::*;

   enc_state_t        state_q;
   enc_state_t        state_d;
   logic              accept;
   logic [LFSR_W-1:0] lfsr_state;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= UNSEEDED;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: any seed load moves to (or stays in) RUN.
   always_comb begin
      state_d = state_q;
      if (i_seed_load) begin
         state_d = RUN;
      end
   end

   // A seed load takes priority over accepting a pair, so the new seed is
   // never mixed with masks drawn in the same cycle.
   assign o_ready = (state_q == RUN) && !i_seed_load && (!o_valid || i_ready);
   assign accept  = i_valid && o_ready;

   mask_lfsr #(
      .RESET_SEED(SEED_DEFAULT)
   ) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (i_seed_load),
      .seed    (i_seed),
      .advance (accept),
      .state   (lfsr_state)
   );

   // Output share register: the only pipeline stage. It loads on accept,
   // drops valid when drained with nothing new behind it, and holds
   // otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid <= 1'b0;
         o_A0    <= 1'b0;
         o_A1    <= 1'b0;
         o_B0    <= 1'b0;
         o_B1    <= 1'b0;
         o_rN    <= 1'b0;
      end else if (accept) begin
         o_valid <= 1'b1;
         o_A0    <= i_A ^ lfsr_state[0];
         o_A1    <= lfsr_state[0];
         o_B0    <= i_B ^ lfsr_state[1];
         o_B1    <= lfsr_state[1];
         o_rN    <= lfsr_state[2];
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end

   // Accepted-encoding counter: saturates, survives reseeding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_count <= 16'h0000;
      end else if (accept && (o_count != 16'hFFFF)) begin
         o_count <= o_count + 16'h0001;
      end
   end

endmodule

// File: tb/tb_share_encoder.sv
// Bench for share_encoder: a hand-written vector table for the handshake
// corners, hand sequences for reset and saturation, and a scoreboard queue
// holding the expected shares of every accepted pair.
module tb_share_encoder;

   logic        clk;
   logic        rst_n;
   logic        i_seed_load;
   logic [15:0] i_seed;
   logic        i_valid;
   logic        o_ready;
   logic        i_A;
   logic        i_B;
   logic        o_valid;
   logic        i_ready;
   logic        o_A0;
   logic        o_A1;
   logic        o_B0;
   logic        o_B1;
   logic        o_rN;
   logic [15:0] o_count;

   share_encoder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_seed_load (i_seed_load),
      .i_seed      (i_seed),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_A         (i_A),
      .i_B         (i_B),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_A0        (o_A0),
      .o_A1        (o_A1),
      .o_B0        (o_B0),
      .o_B1        (o_B1),
      .o_rN        (o_rN),
      .o_count     (o_count)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   // Scoreboard: expected {A0, A1, B0, B1, rN} per accepted pair.
   logic [4:0] exp_q[$];
   logic [4:0] held;

   // Reference model state
   logic        m_run;
   logic        m_valid;
   logic [15:0] m_lfsr;
   logic [15:0] m_count;

   typedef struct {
      logic        sl;
      logic [15:0] seed;
      logic        v;
      logic        a;
      logic        b;
      logic        rdy;
      logic        exp_ready;
      logic        exp_valid;
   } vec_t;

   vec_t tbl[18];

   function automatic logic [15:0] step1(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run   = 1'b0;
      m_valid = 1'b0;
      m_lfsr  = 16'hACE1;
      m_count = 16'h0000;
      held    = 5'b0;
      exp_q.delete();
   endtask

   // One clock cycle, entered and left at posedge+1.
   task automatic cyc(input logic sl, input logic [15:0] seed, input logic v,
                      input logic a, input logic b, input logic rdy,
                      input logic exp_ready, input logic exp_valid, input string name);
      logic       acc;
      logic [4:0] e;
      i_seed_load = sl;
      i_seed      = seed;
      i_valid     = v;
      i_A         = a;
      i_B         = b;
      i_ready     = rdy;
      #1;
      chk({name, ".ready"}, o_ready, exp_ready);
      acc = v && exp_ready;
      if (acc) begin
         exp_q.push_back({a ^ m_lfsr[0], m_lfsr[0], b ^ m_lfsr[1], m_lfsr[1], m_lfsr[2]});
         m_lfsr = step1(step1(step1(m_lfsr)));
         if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      end else if (sl) begin
         m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
      end
      if (sl) m_run = 1'b1;
      @(posedge clk);
      #1;
      chk({name, ".valid"}, o_valid, exp_valid);
      if (acc) begin
         if (exp_q.size() == 0) begin
            chk({name, ".queue"}, 0, 1);
         end else begin
            e = exp_q.pop_front();
            chk({name, ".shares"}, {o_A0, o_A1, o_B0, o_B1, o_rN}, e);
            chk({name, ".xor"}, {o_A0 ^ o_A1, o_B0 ^ o_B1}, {a, b});
            held = e;
         end
      end else if (exp_valid) begin
         chk({name, ".hold"}, {o_A0, o_A1, o_B0, o_B1, o_rN}, held);
      end
      chk({name, ".lfsr"}, dut.u_lfsr.state, m_lfsr);
      chk({name, ".count"}, o_count, m_count);
      m_valid = exp_valid;
   endtask

   // Expectations from the model instead of a table row.
   task automatic auto_cyc(input logic sl, input logic [15:0] seed, input logic v,
                           input logic a, input logic b, input logic rdy, input string name);
      logic er;
      logic ev;
      er = m_run && !sl && (!m_valid || rdy);
      ev = (v && er) || (m_valid && !rdy);
      cyc(sl, seed, v, a, b, rdy, er, ev, name);
   endtask

   task automatic check_reset_values(input string name);
      chk({name, ".valid"}, o_valid, 1'b0);
      chk({name, ".shares"}, {o_A0, o_A1, o_B0, o_B1, o_rN}, 5'b0);
      chk({name, ".count"}, o_count, 16'h0);
      chk({name, ".state"}, dut.state_q, 1'b0);
      chk({name, ".lfsr"}, dut.u_lfsr.state, 16'hACE1);
   endtask

   initial begin
      // fields: sl, seed, v, a, b, rdy, exp_ready, exp_valid(after edge)
      tbl[0]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // unseeded
      tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 16'hACE1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // seed wins
      tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}; // A=1,B=1
      tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}; // back-to-back
      tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // drain
      tbl[7]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // zero seed
      tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // stall x5
      tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[14] = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}; // reseed, pending kept
      tbl[15] = '{1'b1, 16'h4321, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // reseed, consumed
      tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      // Reset
      rst_n       = 1'b0;
      i_seed_load = 1'b0;
      i_seed      = 16'h0;
      i_valid     = 1'b0;
      i_A         = 1'b0;
      i_B         = 1'b0;
      i_ready     = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst_n = 1'b1;

      // Table-driven corners
      for (int i = 0; i < 18; i++) begin
         cyc(tbl[i].sl, tbl[i].seed, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].rdy,
             tbl[i].exp_ready, tbl[i].exp_valid, $sformatf("vec%0d", i));
         if (i == 4) begin
            chk("first.shares", {o_A0, o_A1, o_B0, o_B1, o_rN}, 5'b01100);
            chk("first.lfsr", dut.u_lfsr.state, 16'h559C);
         end
         if (i == 5) chk("second.shares", {o_A0, o_A1, o_B0, o_B1, o_rN}, 5'b00101);
         if (i == 7) chk("zero_seed.lfsr", dut.u_lfsr.state, 16'hACE1);
         if (i == 14) chk("reseed.lfsr", dut.u_lfsr.state, 16'h1234);
      end

      // Random traffic
      for (int i = 0; i < 200; i++) begin
         logic sl;
         logic [15:0] sd;
         sl = ($urandom_range(0, 9) == 0);
         sd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(0, 65535));
         auto_cyc(sl, sd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), "rand");
      end

      // Reset in the middle of a pending encoding
      auto_cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, "pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("mid_reset");
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "post_rst");
      end

      // Continuous accepts up to and past counter saturation
      cyc(1'b1, 16'hACE1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "sat_seed");
      for (int i = 0; i < 65537; i++) begin
         cyc(1'b0, 16'h0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'b1, 1'b1, 1'b1, "stream");
      end
      chk("sat.count", o_count, 16'hFFFF);
      cyc(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "sat_reseed");
      chk("sat.kept", o_count, 16'hFFFF);
      chk("sat.queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
